// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address check for the data-memory responder
package dmem_pkg;

    localparam int WSTRB_W = 4;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when addr is word aligned and falls inside [base, base + depth*4).
    // The subtraction wraps, so addresses below base become huge offsets and fail.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
        logic [31:0] off;
        logic [31:0] limit;
        off   = addr - base;
        limit = depth << 2;
        return (addr[1:0] == 2'b00) && (off < limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with byte-lane writes and registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic [WSTRB_W-1:0] we,
    input  logic               re,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read register only updates on an enabled read so it holds across the response
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Storage and read register; the array is never reset
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        for (int i = 0; i < WSTRB_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - one-at-a-time load/store responder with programmable wait states
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [WSTRB_W-1:0]  req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [31:0]          addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [WSTRB_W-1:0]   wstrb_q, wstrb_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_load_q, rsp_load_d;

    logic                 access;
    logic                 ok;
    logic [31:0]          off;
    logic [IDX_W-1:0]     idx;
    logic [WSTRB_W-1:0]   ram_we;
    logic                 ram_re;
    logic [DATA_W-1:0]    ram_rdata;
    logic                 unused_off;

    // The access edge is the last WAIT cycle; RAM read/write happen exactly there
    assign access     = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign ok         = addr_ok(addr_q, BASE_ADDR, DEPTH_WORDS);
    assign off        = addr_q - BASE_ADDR;
    assign idx        = off[IDX_W+1:2];
    assign unused_off = ^{off[31:IDX_W+2], off[1:0]};
    assign ram_we     = (access && wr_q && ok) ? wstrb_q : '0;
    assign ram_re     = access && !wr_q && ok;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next-state logic for the request/wait/response sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_load_d  = rsp_load_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    cnt_d       = WAIT_CNT;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !ok;
                    rsp_load_d  = !wr_q && ok;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_load_d  = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_load_d  = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // Stores and errors never enable the read register path, so they return zero
    assign rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT=2 and WAIT=0 builds)
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic prev_v = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    function automatic int wcyc();
        return sel ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: latency on each new response, data/err on each response handshake
    always @(negedge clk) begin
        #1;
        if (m_rsp_valid && !prev_v) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(m_rsp_valid), 32'd0);
            end else begin
                chk("latency", 32'(cyc - q[0].acc), 32'(wcyc() + 1));
            end
        end
        if (m_rsp_valid && rsp_ready && q.size() > 0) begin
            chk("rsp_rdata", m_rsp_rdata, q[0].rdata);
            chk("rsp_err", 32'(m_rsp_err), 32'(q[0].err));
            void'(q.pop_front());
        end
        prev_v = m_rsp_valid;
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rdata,
                         input bit wait_rsp, input bit chk_space);
        int   n;
        exp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        n = 0;
        while (!m_req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!m_req_ready) begin
            chk("accept_timeout", 32'(m_req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.acc   = cyc + 1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        q.push_back(e);
        if (chk_space) chk("accept_spacing", 32'(e.acc - last_acc), 32'(wcyc() + 3));
        last_acc = e.acc;
        @(negedge clk);
        req_valid = 1'b0;
        if (wait_rsp) begin
            n = 0;
            while (q.size() != 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                chk("rsp_timeout", 32'(q.size()), 32'd0);
                q.delete();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; sel = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_req_ready", 32'(m_req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("reset_rsp_rdata", m_rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(m_rsp_err), 32'd0);
        @(negedge clk);

        // Full-word store then load, WAIT=2
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);

        // Byte lanes and empty strobe
        issue(1'b1, 32'h30, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1, 1'b0);
        issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1, 1'b0);

        // Errors: misaligned, one past the end, below base
        issue(1'b0, 32'h02, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h0, 32'h01010101, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h3FC, 32'h02020202, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h01010101, 1'b1, 1'b0);
        issue(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, 32'h02020202, 1'b1, 1'b0);
        issue(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0);

        // Backpressure: response held while a second request waits
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        n = 0;
        while (!m_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; req_wstrb = 4'h0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(m_rsp_valid), 32'd1);
            chk("bp_rsp_rdata", m_rsp_rdata, 32'hDEADBEEF);
            chk("bp_rsp_err", 32'(m_rsp_err), 32'd0);
            chk("bp_req_ready", 32'(m_req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1, 1'b0);

        // Reset during the wait of a store
        issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(m_req_ready), 32'd1);
        chk("midrst_rsp_rdata", m_rsp_rdata, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);

        // WAIT=0 build at base 0x1000: back-to-back traffic
        sel = 1'b1;
        @(negedge clk);
        issue(1'b1, 32'h1000, 32'hA5A50001, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h1004, 32'h5A5A0002, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 32'h13FC, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h1004, 32'h0, 4'h0, 1'b0, 32'h5A5A0002, 1'b0, 1'b1);
        issue(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 32'hA5A50001, 1'b0, 1'b1);
        issue(1'b0, 32'h13FC, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b0, 1'b1);
        issue(1'b0, 32'h0FFC, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h1400, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h1002, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b1);

        repeat (4) @(negedge clk);
        if (q.size() != 0) chk("leftover_rsp", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
